mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the instruction-fetch stage and the MEM stage of the 5-stage pipeline CPU.
- Serialises the two requesters with a handshake and returns read data.
- Its per-requester acks drive the pipeline stall logic: a stage stalls while its req is high and its ack is low.
- Sits between the pipeline registers and the unified memory model.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between fetch and data ports.
// One grant at a time: IDLE -> BUSY (LATENCY cycles) -> RESP (ack) -> IDLE.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int LATENCY       = 2,
  parameter int DATA_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         DPRI     = (DATA_PRIORITY != 0);

  state_t     state;
  logic [3:0] cnt;
  logic       last_d;
  logic       win_d;
  logic       pick_d;

  // Ties go to data, or to the port not granted last time.
  always_comb begin
    pick_d = d_req && (!if_req || DPRI || !last_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      win_d     <= 1'b0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= BUSY;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            cnt    <= CNT_INIT;
            win_d  <= pick_d;
            last_d <= pick_d;
            if (pick_d) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (win_d) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four parameter sets driven by queued requesters,
// checked every cycle against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int NI = 4;
  localparam int LAT [NI] = '{2, 2, 1, 15};
  localparam int DP  [NI] = '{1, 0, 1, 0};

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NI-1:0]        if_req, if_ack, d_req, d_we, d_ack;
  logic [NI-1:0]        mem_en, mem_we, busy;
  logic [NI-1:0][31:0]  if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [NI-1:0][31:0]  mem_addr, mem_wdata, mem_rdata;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    int          en_cnt = 0;
    logic [31:0] noise  = '0;

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .LATENCY(LAT[g]), .DATA_PRIORITY(DP[g])
    ) u_dut (
      .clk(clk), .reset(rst_n),
      .if_req(if_req[g]), .if_addr(if_addr[g]),
      .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
      .d_req(d_req[g]), .d_we(d_we[g]),
      .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Memory returns valid data only in the last cycle of the window.
    always @(posedge clk) begin
      en_cnt <= mem_en[g] ? en_cnt + 1 : 0;
      noise  <= $urandom;
    end
    assign mem_rdata[g] = (mem_en[g] && en_cnt == LAT[g] - 1) ?
                          memfn(mem_addr[g]) : noise;
  end

  int          checks, errors, k;
  bit          act [NI];
  int          gk [NI];
  bit          win [NI];
  bit          lastg [NI];
  bit          mwe [NI];
  logic [31:0] maddr [NI], mwdata [NI], e_ifr [NI], e_dr [NI];
  bit          was_rst;
  req_t        fifo [NI][2][64];
  int          hd [NI][2];
  int          cntq [NI][2];

  function automatic req_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] wd);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd;
    return r;
  endfunction

  task automatic push(input int p, input req_t r);
    for (int g = 0; g < NI; g++) begin
      fifo[g][p][(hd[g][p] + cntq[g][p]) % 64] = r;
      cntq[g][p]++;
    end
  endtask

  task automatic pop(input int g, input int p);
    hd[g][p] = (hd[g][p] + 1) % 64;
    cntq[g][p]--;
  endtask

  task automatic chk(input string tag, input int g,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cycle %0d: got %h expected %h",
             tag, g, k, obs, exp);
    end
  endtask

  task automatic model_edge();
    int dd;
    bit w;
    was_rst = !rst_n;
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        act[g] = 0; lastg[g] = 0; mwe[g] = 0;
        maddr[g] = '0; mwdata[g] = '0;
        e_ifr[g] = '0; e_dr[g] = '0;
      end else begin
        dd = k - gk[g];
        if (act[g] && dd == LAT[g]) begin
          if (!win[g]) e_ifr[g] = memfn(maddr[g]);
          else if (!mwe[g]) e_dr[g] = memfn(maddr[g]);
        end
        if (act[g] && dd == LAT[g] + 1) begin
          act[g] = 0;
        end else if (!act[g] && (if_req[g] || d_req[g])) begin
          if (if_req[g] && d_req[g]) w = (DP[g] != 0) ? 1'b1 : !lastg[g];
          else w = d_req[g];
          act[g] = 1; gk[g] = k; win[g] = w; lastg[g] = w;
          if (w) begin
            maddr[g] = d_addr[g]; mwe[g] = d_we[g]; mwdata[g] = d_wdata[g];
          end else begin
            maddr[g] = if_addr[g]; mwe[g] = 0; mwdata[g] = '0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int dd;
    bit en, ia, da;
    for (int g = 0; g < NI; g++) begin
      dd = k - gk[g];
      en = act[g] && dd < LAT[g];
      ia = act[g] && dd == LAT[g] && !win[g];
      da = act[g] && dd == LAT[g] && win[g];
      chk("mem_en", g, 32'(mem_en[g]), 32'(en));
      chk("mem_we", g, 32'(mem_we[g]), 32'(en && mwe[g]));
      chk("if_ack", g, 32'(if_ack[g]), 32'(ia));
      chk("d_ack", g, 32'(d_ack[g]), 32'(da));
      chk("busy", g, 32'(busy[g]), 32'(act[g]));
      chk("if_rdata", g, if_rdata[g], e_ifr[g]);
      chk("d_rdata", g, d_rdata[g], e_dr[g]);
      if (en || was_rst) chk("mem_addr", g, mem_addr[g], maddr[g]);
      if ((en && mwe[g]) || was_rst)
        chk("mem_wdata", g, mem_wdata[g], mwdata[g]);
      if (ia) pop(g, 0);
      if (da) pop(g, 1);
    end
  endtask

  task automatic drive();
    req_t r;
    for (int g = 0; g < NI; g++) begin
      if (cntq[g][0] > 0) begin
        r = fifo[g][0][hd[g][0]];
        if_req[g] = 1'b1; if_addr[g] = r.addr;
      end else begin
        if_req[g] = 1'b0; if_addr[g] = $urandom;
      end
      if (cntq[g][1] > 0) begin
        r = fifo[g][1][hd[g][1]];
        d_req[g] = 1'b1; d_we[g] = r.we;
        d_addr[g] = r.addr; d_wdata[g] = r.wdata;
      end else begin
        d_req[g] = 1'b0; d_we[g] = 1'($urandom);
        d_addr[g] = $urandom; d_wdata[g] = $urandom;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    model_edge();
    @(negedge clk);
    check_all();
    drive();
  endtask

  function automatic int pending();
    int n = 0;
    for (int g = 0; g < NI; g++)
      n += cntq[g][0] + cntq[g][1] + int'(act[g]);
    return n;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 0, 32'(pending()), 32'd0);
  endtask

  function automatic bit room(input int p);
    for (int g = 0; g < NI; g++)
      if (cntq[g][p] >= 6) return 0;
    return 1;
  endfunction

  initial begin
    checks = 0; errors = 0; k = 0;
    for (int g = 0; g < NI; g++) begin
      maddr[g] = '0; mwdata[g] = '0; e_ifr[g] = '0; e_dr[g] = '0;
    end
    rst_n = 1'b0;
    push(0, mk(1'b0, 32'h40, 32'h0));
    drive();
    step();
    step();
    rst_n = 1'b1;
    drain(60);

    push(1, mk(1'b0, $urandom, 32'h0));
    push(1, mk(1'b1, 32'h100, 32'hDEAD_BEEF));
    drive();
    drain(80);

    push(0, mk(1'b0, $urandom, 32'h0));
    push(1, mk(1'b0, $urandom, 32'h0));
    drive();
    drain(80);

    rst_n = 1'b0;
    drive();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, mk(1'b0, $urandom, 32'h0));
      push(1, mk(1'($urandom), $urandom, $urandom));
    end
    drive();
    drain(300);

    push(0, mk(1'b0, $urandom, 32'h0));
    drive();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drain(100);

    for (int i = 0; i < 6; i++) push(0, mk(1'b0, $urandom, 32'h0));
    drive();
    drain(200);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && room(0))
        push(0, mk(1'b0, $urandom, 32'h0));
      if ($urandom_range(0, 3) == 0 && room(1))
        push(1, mk(1'($urandom), $urandom, $urandom));
      rst_n = ($urandom_range(0, 99) != 0);
      drive();
      step();
    end
    rst_n = 1'b1;
    drive();
    drain(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
